// File: rtl/time_param_pkg.sv
// Shared constants for the traffic-light interval/countdown block: interval
// indices and the default duration (seconds) of each interval.
package time_param_pkg;

  localparam int VAL_W_DEF     = 4;
  localparam int NUM_INTERVALS_DEF = 4;

  localparam int IDX_BASE = 0;
  localparam int IDX_EXT  = 1;
  localparam int IDX_YEL  = 2;
  localparam int IDX_WALK = 3;

  localparam int DEF_BASE = 6;
  localparam int DEF_EXT  = 3;
  localparam int DEF_YEL  = 2;
  localparam int DEF_WALK = 4;

endpackage

// File: rtl/interval_countdown.sv
// Single countdown register: load has priority over the 1 Hz tick, and a
// one-cycle expired pulse marks the tick that takes remaining from 1 to 0.
module interval_countdown
  import time_param_pkg::*;
#(
  parameter int VAL_W = VAL_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [VAL_W-1:0] load_value,
  input  logic             one_hz_enable,
  output logic [VAL_W-1:0] remaining,
  output logic             busy,
  output logic             expired
);

  logic [VAL_W-1:0] r_remaining;
  logic             r_expired;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_remaining <= '0;
      r_expired   <= 1'b0;
    end else begin
      r_expired <= 1'b0;
      if (load) begin
        // A tick in the same cycle is dropped, so the load buys N full ticks.
        r_remaining <= load_value;
      end else if (one_hz_enable && (r_remaining != '0)) begin
        r_remaining <= r_remaining - 1'b1;
        r_expired   <= (r_remaining == VAL_W'(1));
      end
    end
  end

  assign remaining = r_remaining;
  assign busy      = (r_remaining != '0);
  assign expired   = r_expired;

endmodule

// File: rtl/time_param_timer.sv
// Programmable interval durations with per-interval defaults, plus a countdown
// that the traffic-light FSM starts on a chosen interval.
module time_param_timer
  import time_param_pkg::*;
#(
  parameter int NUM_INTERVALS = NUM_INTERVALS_DEF,
  parameter int VAL_W         = VAL_W_DEF,
  parameter int SEL_W         = (NUM_INTERVALS > 1) ? $clog2(NUM_INTERVALS) : 1,
  parameter logic [NUM_INTERVALS*VAL_W-1:0] DEFAULTS =
    {VAL_W'(DEF_WALK), VAL_W'(DEF_YEL), VAL_W'(DEF_EXT), VAL_W'(DEF_BASE)}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEL_W-1:0] Selector,
  input  logic [VAL_W-1:0] Time_value,
  input  logic             Prog_Sync,
  input  logic [SEL_W-1:0] interval,
  output logic [VAL_W-1:0] value,
  input  logic             start_timer,
  input  logic             one_hz_enable,
  output logic [VAL_W-1:0] remaining,
  output logic             busy,
  output logic             expired
);

  logic [VAL_W-1:0] w_param [NUM_INTERVALS];
  logic             w_sel_valid;
  logic             w_int_valid;
  logic             w_load;

  assign w_sel_valid = (int'(Selector) < NUM_INTERVALS);
  assign w_int_valid = (int'(interval) < NUM_INTERVALS);

  for (genvar i = 0; i < NUM_INTERVALS; i++) begin : g_param
    localparam logic [VAL_W-1:0] DEF = DEFAULTS[i*VAL_W +: VAL_W];
    logic [VAL_W-1:0] r_val;

    // NOTE: this small register file is reset element by element because the
    // defaults must be valid immediately after reset; large RAMs would not be.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_val <= DEF;
      end else if (Prog_Sync && w_sel_valid && (Selector == SEL_W'(i))) begin
        r_val <= (Time_value == '0) ? DEF : Time_value;
      end
    end

    assign w_param[i] = r_val;
  end

  // The countdown loads from the registered value, so a same-cycle write is
  // not seen until the next start.
  assign value  = w_int_valid ? w_param[interval] : '0;
  assign w_load = start_timer && w_int_valid;

  interval_countdown #(
    .VAL_W(VAL_W)
  ) u_countdown (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (w_load),
    .load_value   (value),
    .one_hz_enable(one_hz_enable),
    .remaining    (remaining),
    .busy         (busy),
    .expired      (expired)
  );

endmodule

// File: tb/tb_time_param_timer.sv
// Directed bench for time_param_timer: defaults, programming, countdown,
// start/program collisions, restart and asynchronous reset.
module tb_time_param_timer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] Selector;
  logic [3:0] Time_value;
  logic       Prog_Sync;
  logic [1:0] interval;
  logic [3:0] value;
  logic       start_timer;
  logic       one_hz_enable;
  logic [3:0] remaining;
  logic       busy;
  logic       expired;

  int n_vec = 0;
  int n_err = 0;

  time_param_timer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .Selector     (Selector),
    .Time_value   (Time_value),
    .Prog_Sync    (Prog_Sync),
    .interval     (interval),
    .value        (value),
    .start_timer  (start_timer),
    .one_hz_enable(one_hz_enable),
    .remaining    (remaining),
    .busy         (busy),
    .expired      (expired)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] exp_def [4];
    exp_def = '{4'd6, 4'd3, 4'd2, 4'd4};
    rst_n = 1'b0; Selector = '0; Time_value = '0; Prog_Sync = 1'b0;
    interval = '0; start_timer = 1'b0; one_hz_enable = 1'b0;
    #12 rst_n = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      interval = 2'(i);
      #1;
      n_vec++;
      if (value !== exp_def[i]) begin
        n_err++; $display("FAIL reset_default[%0d]: got %0d expected %0d", i, value, exp_def[i]);
      end
    end
    n_vec++;
    if (remaining !== 4'd0 || busy !== 1'b0 || expired !== 1'b0) begin
      n_err++; $display("FAIL reset_timer: got rem=%0d busy=%b exp=%b expected 0/0/0", remaining, busy, expired);
    end
  endtask

  task automatic test_program();
    interval = 2'd1; Selector = 2'd1; Time_value = 4'd10; Prog_Sync = 1'b1;
    #1;
    n_vec++;
    if (value !== 4'd3) begin
      n_err++; $display("FAIL prog_before_edge: got %0d expected 3", value);
    end
    step();
    Prog_Sync = 1'b0; Time_value = 4'd0;
    n_vec++;
    if (value !== 4'd10) begin
      n_err++; $display("FAIL prog_write10: got %0d expected 10", value);
    end
    Prog_Sync = 1'b1;
    step();
    Prog_Sync = 1'b0;
    n_vec++;
    if (value !== 4'd3) begin
      n_err++; $display("FAIL prog_restore_default: got %0d expected 3", value);
    end
    interval = 2'd0;
    #1;
    n_vec++;
    if (value !== 4'd6) begin
      n_err++; $display("FAIL prog_other_untouched: got %0d expected 6", value);
    end
  endtask

  task automatic test_countdown();
    logic [3:0] exp_rem [2];
    exp_rem = '{4'd1, 4'd0};
    interval = 2'd2; start_timer = 1'b1;
    step();
    start_timer = 1'b0;
    n_vec++;
    if (remaining !== 4'd2 || busy !== 1'b1 || expired !== 1'b0) begin
      n_err++; $display("FAIL cd_load: got rem=%0d busy=%b exp=%b expected 2/1/0", remaining, busy, expired);
    end
    for (int t = 0; t < 2; t++) begin
      repeat (9) step();
      n_vec++;
      if (remaining !== 4'd2 - 4'(t) || expired !== 1'b0) begin
        n_err++; $display("FAIL cd_hold[%0d]: got rem=%0d exp=%b expected %0d/0", t, remaining, expired, 2 - t);
      end
      one_hz_enable = 1'b1;
      step();
      one_hz_enable = 1'b0;
      n_vec++;
      if (remaining !== exp_rem[t] || busy !== (t == 0) || expired !== (t == 1)) begin
        n_err++; $display("FAIL cd_tick[%0d]: got rem=%0d busy=%b exp=%b expected %0d/%b/%b",
                          t, remaining, busy, expired, exp_rem[t], (t == 0), (t == 1));
      end
    end
    step();
    n_vec++;
    if (expired !== 1'b0 || remaining !== 4'd0) begin
      n_err++; $display("FAIL cd_pulse_width: got rem=%0d exp=%b expected 0/0", remaining, expired);
    end
    one_hz_enable = 1'b1;
    step();
    one_hz_enable = 1'b0;
    n_vec++;
    if (remaining !== 4'd0 || expired !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL cd_idle_tick: got rem=%0d busy=%b exp=%b expected 0/0/0", remaining, busy, expired);
    end
  endtask

  task automatic test_same_cycle();
    Selector = 2'd0; Time_value = 4'd9; Prog_Sync = 1'b1;
    interval = 2'd0; start_timer = 1'b1;
    step();
    Prog_Sync = 1'b0; start_timer = 1'b0;
    n_vec++;
    if (remaining !== 4'd6) begin
      n_err++; $display("FAIL same_cycle_load: got %0d expected 6", remaining);
    end
    n_vec++;
    if (value !== 4'd9) begin
      n_err++; $display("FAIL same_cycle_write: got %0d expected 9", value);
    end
    step();
    start_timer = 1'b1;
    step();
    start_timer = 1'b0;
    n_vec++;
    if (remaining !== 4'd9) begin
      n_err++; $display("FAIL later_start_load: got %0d expected 9", remaining);
    end
  endtask

  task automatic test_back_to_back();
    logic seen_exp;
    Selector = 2'd0; Time_value = 4'd0; Prog_Sync = 1'b1;
    step();
    Prog_Sync = 1'b0;
    interval = 2'd0; start_timer = 1'b1; one_hz_enable = 1'b1;
    step();
    start_timer = 1'b0; one_hz_enable = 1'b0;
    n_vec++;
    if (remaining !== 4'd6) begin
      n_err++; $display("FAIL start_with_tick: got %0d expected 6", remaining);
    end
    seen_exp = 1'b0;
    for (int t = 0; t < 4; t++) begin
      one_hz_enable = 1'b1;
      step();
      one_hz_enable = 1'b0;
      step();
      seen_exp |= expired;
    end
    n_vec++;
    if (remaining !== 4'd2) begin
      n_err++; $display("FAIL four_ticks: got %0d expected 2", remaining);
    end
    interval = 2'd1; start_timer = 1'b1;
    step();
    start_timer = 1'b0;
    seen_exp |= expired;
    n_vec++;
    if (remaining !== 4'd3 || busy !== 1'b1) begin
      n_err++; $display("FAIL restart_load: got rem=%0d busy=%b expected 3/1", remaining, busy);
    end
    n_vec++;
    if (seen_exp !== 1'b0) begin
      n_err++; $display("FAIL restart_no_expired: got %b expected 0", seen_exp);
    end
    one_hz_enable = 1'b1;
    step();
    one_hz_enable = 1'b0;
    n_vec++;
    if (remaining !== 4'd2) begin
      n_err++; $display("FAIL restart_tick: got %0d expected 2", remaining);
    end
    // A start coincident with the final tick preempts it: no expired.
    step();
    one_hz_enable = 1'b1;
    step();
    n_vec++;
    if (remaining !== 4'd1) begin
      n_err++; $display("FAIL preempt_setup: got %0d expected 1", remaining);
    end
    interval = 2'd2; start_timer = 1'b1;
    step();
    start_timer = 1'b0; one_hz_enable = 1'b0;
    n_vec++;
    if (remaining !== 4'd2 || expired !== 1'b0) begin
      n_err++; $display("FAIL preempt_final_tick: got rem=%0d exp=%b expected 2/0", remaining, expired);
    end
  endtask

  task automatic test_async_reset();
    logic seen_exp;
    Selector = 2'd2; Time_value = 4'd7; Prog_Sync = 1'b1;
    step();
    Prog_Sync = 1'b0;
    interval = 2'd3; start_timer = 1'b1;
    step();
    start_timer = 1'b0;
    n_vec++;
    if (remaining !== 4'd4) begin
      n_err++; $display("FAIL rst_setup: got %0d expected 4", remaining);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (remaining !== 4'd0 || busy !== 1'b0) begin
      n_err++; $display("FAIL async_clear: got rem=%0d busy=%b expected 0/0", remaining, busy);
    end
    interval = 2'd2;
    #1;
    n_vec++;
    if (value !== 4'd2) begin
      n_err++; $display("FAIL rst_param_default: got %0d expected 2", value);
    end
    step();
    #2 rst_n = 1'b1;
    seen_exp = 1'b0;
    for (int t = 0; t < 6; t++) begin
      one_hz_enable = t[0];
      step();
      seen_exp |= expired;
    end
    one_hz_enable = 1'b0;
    n_vec++;
    if (seen_exp !== 1'b0 || remaining !== 4'd0) begin
      n_err++; $display("FAIL rst_no_expired: got exp=%b rem=%0d expected 0/0", seen_exp, remaining);
    end
  endtask

  initial begin
    test_reset();
    test_program();
    test_countdown();
    test_same_cycle();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
